// File: rtl/sort_pulse_pkg.sv
// Shared constants for the sort-actuator pulse generator: widths, state encoding,
// register offsets and reset defaults.
package sort_pulse_pkg;

   localparam int unsigned DWD = 14;
   localparam int unsigned MEM = 32;
   localparam int unsigned CNW = 16;
   localparam int unsigned AMW = 13;
   localparam int unsigned AW  = 20;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      POS  = 2'd1,
      NEG  = 2'd2
   } state_t;

   localparam logic [AW-1:0] ADDR_ENABLE = 20'h00000;
   localparam logic [AW-1:0] ADDR_AMP    = 20'h00004;
   localparam logic [AW-1:0] ADDR_HP     = 20'h00008;
   localparam logic [AW-1:0] ADDR_NCYC   = 20'h0000C;
   localparam logic [AW-1:0] ADDR_ABORT  = 20'h00010;
   localparam logic [AW-1:0] ADDR_DONE   = 20'h00100;
   localparam logic [AW-1:0] ADDR_MISSED = 20'h00104;
   localparam logic [AW-1:0] ADDR_STATE  = 20'h00108;
   localparam logic [AW-1:0] ADDR_CLEAR  = 20'h0010C;

   localparam logic           DEF_ENABLE = 1'b1;
   localparam logic [AMW-1:0] DEF_AMP    = 13'd4000;
   localparam logic [MEM-1:0] DEF_HP     = 32'd62500;
   localparam logic [CNW-1:0] DEF_NCYC   = 16'd10;

   // A half period of 0 would never terminate a phase; clamp it to 1.
   function automatic logic [MEM-1:0] hp_eff(input logic [MEM-1:0] hp);
      return (hp == '0) ? MEM'(1) : hp;
   endfunction

   function automatic logic signed [DWD-1:0] to_dac(input logic [AMW-1:0] amp, input logic neg);
      logic signed [DWD-1:0] v;
      v = signed'(DWD'(amp));
      return neg ? -v : v;
   endfunction

endpackage

// File: rtl/sort_pulse_if.sv
// System-bus responder signalling shared with the FADS block.
interface sort_pulse_if;
   logic [31:0] sys_addr;
   logic [31:0] sys_wdata;
   logic [3:0]  sys_sel;
   logic        sys_wen;
   logic        sys_ren;
   logic [31:0] sys_rdata;
   logic        sys_err;
   logic        sys_ack;

   modport master (output sys_addr, sys_wdata, sys_sel, sys_wen, sys_ren,
                   input  sys_rdata, sys_err, sys_ack);
   modport slave  (input  sys_addr, sys_wdata, sys_sel, sys_wen, sys_ren,
                   output sys_rdata, sys_err, sys_ack);
endinterface

// File: rtl/sort_edge_detect.sv
// Registers a level input twice and flags its rising edge (one cycle wide).
module sort_edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic sig,
   output logic rise_c
);
   logic sig_q;
   logic sig_q2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sig_q  <= 1'b0;
         sig_q2 <= 1'b0;
      end else begin
         sig_q  <= sig;
         sig_q2 <= sig_q;
      end
   end

   assign rise_c = sig_q & ~sig_q2;
endmodule

// File: rtl/red_pitaya_sort_pulse_gen.sv
// Sort-actuator waveform generator: a trigger rising edge launches a bipolar
// square burst on the DAC; configuration and status live on the system bus.
module red_pitaya_sort_pulse_gen
   import sort_pulse_pkg::*;
(
   input  logic                  adc_clk_i,
   input  logic                  adc_rst_i,
   input  logic                  trig_i,
   output logic signed [DWD-1:0] dac_o,
   output logic                  busy_o,
   sort_pulse_if.slave           sys
);

   logic           rise_c;
   logic [AW-1:0]  addr_c;
   logic           abort_c, disable_c, clear_c;
   logic           enable_q;
   logic [AMW-1:0] amp_q, amp_sh_q, amp_sh_d;
   logic [MEM-1:0] hp_q, hp_sh_q, hp_sh_d;
   logic [CNW-1:0] ncyc_q, left_q, left_d;
   logic [MEM-1:0] cnt_q, cnt_d;
   logic [MEM-1:0] done_q, missed_q;
   logic           done_c, miss_c;
   state_t         state_q, state_d;
   logic signed [DWD-1:0] dac_d;
   logic [MEM-1:0] rd_c;
   wire            unused_ok = &{1'b0, sys.sys_sel, sys.sys_addr[31:AW]};

   sort_edge_detect u_trig (
      .clk    (adc_clk_i),
      .rst    (adc_rst_i),
      .sig    (trig_i),
      .rise_c (rise_c)
   );

   assign addr_c    = sys.sys_addr[AW-1:0];
   assign abort_c   = sys.sys_wen && (addr_c == ADDR_ABORT)  &&  sys.sys_wdata[0];
   assign disable_c = sys.sys_wen && (addr_c == ADDR_ENABLE) && !sys.sys_wdata[0];
   assign clear_c   = sys.sys_wen && (addr_c == ADDR_CLEAR)  &&  sys.sys_wdata[0];

   // Configuration registers; bursts only see them through the shadow copies.
   always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
      if (adc_rst_i) begin
         enable_q <= DEF_ENABLE;
         amp_q    <= DEF_AMP;
         hp_q     <= DEF_HP;
         ncyc_q   <= DEF_NCYC;
      end else if (sys.sys_wen) begin
         case (addr_c)
            ADDR_ENABLE: enable_q <= sys.sys_wdata[0];
            ADDR_AMP:    amp_q    <= sys.sys_wdata[AMW-1:0];
            ADDR_HP:     hp_q     <= sys.sys_wdata;
            ADDR_NCYC:   ncyc_q   <= sys.sys_wdata[CNW-1:0];
            default: ;
         endcase
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      left_d   = left_q;
      amp_sh_d = amp_sh_q;
      hp_sh_d  = hp_sh_q;
      dac_d    = dac_o;
      done_c   = 1'b0;
      miss_c   = 1'b0;
      case (state_q)
         IDLE: begin
            if (rise_c) begin
               if (!enable_q) begin
                  miss_c = 1'b1;
               end else if (ncyc_q != '0) begin
                  state_d  = POS;
                  amp_sh_d = amp_q;
                  hp_sh_d  = hp_eff(hp_q);
                  left_d   = ncyc_q;
                  cnt_d    = '0;
                  dac_d    = to_dac(amp_q, 1'b0);
               end
            end
         end
         POS: begin
            miss_c = rise_c;
            if (cnt_q == hp_sh_q - MEM'(1)) begin
               state_d = NEG;
               cnt_d   = '0;
               dac_d   = to_dac(amp_sh_q, 1'b1);
            end else begin
               cnt_d = cnt_q + MEM'(1);
            end
         end
         NEG: begin
            miss_c = rise_c;
            if (cnt_q == hp_sh_q - MEM'(1)) begin
               left_d = left_q - CNW'(1);
               cnt_d  = '0;
               if (left_q == CNW'(1)) begin
                  state_d = IDLE;
                  dac_d   = '0;
                  done_c  = 1'b1;
               end else begin
                  state_d = POS;
                  dac_d   = to_dac(amp_sh_q, 1'b0);
               end
            end else begin
               cnt_d = cnt_q + MEM'(1);
            end
         end
         default: begin
            state_d = IDLE;
            dac_d   = '0;
         end
      endcase
      // Abort or disable cancels the burst without counting it as done.
      if ((abort_c || disable_c) && state_q != IDLE) begin
         state_d = IDLE;
         cnt_d   = '0;
         left_d  = '0;
         dac_d   = '0;
         done_c  = 1'b0;
      end
   end

   always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
      if (adc_rst_i) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         left_q   <= '0;
         amp_sh_q <= '0;
         hp_sh_q  <= '0;
         dac_o    <= '0;
         busy_o   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         left_q   <= left_d;
         amp_sh_q <= amp_sh_d;
         hp_sh_q  <= hp_sh_d;
         dac_o    <= dac_d;
         busy_o   <= (state_d != IDLE);
      end
   end

   // Status counters; a clear in the same cycle as an increment wins.
   always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
      if (adc_rst_i) begin
         done_q   <= '0;
         missed_q <= '0;
      end else if (clear_c) begin
         done_q   <= '0;
         missed_q <= '0;
      end else begin
         if (done_c) done_q   <= done_q + MEM'(1);
         if (miss_c) missed_q <= missed_q + MEM'(1);
      end
   end

   always_comb begin
      rd_c = '0;
      case (addr_c)
         ADDR_ENABLE: rd_c = MEM'(enable_q);
         ADDR_AMP:    rd_c = MEM'(amp_q);
         ADDR_HP:     rd_c = hp_q;
         ADDR_NCYC:   rd_c = MEM'(ncyc_q);
         ADDR_DONE:   rd_c = done_q;
         ADDR_MISSED: rd_c = missed_q;
         ADDR_STATE:  rd_c = MEM'(state_q);
         default:     rd_c = '0;
      endcase
   end

   always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
      if (adc_rst_i) begin
         sys.sys_rdata <= '0;
         sys.sys_ack   <= 1'b0;
         sys.sys_err   <= 1'b0;
      end else begin
         sys.sys_rdata <= sys.sys_ren ? rd_c : '0;
         sys.sys_ack   <= sys.sys_wen | sys.sys_ren;
         sys.sys_err   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_red_pitaya_sort_pulse_gen.sv
// Directed bench for the sort-actuator pulse generator.
module tb_red_pitaya_sort_pulse_gen;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               trig = 1'b0;
   logic signed [13:0] dac;
   logic               busy;
   int                 vecs = 0;
   int                 errs = 0;
   int                 exp_done = 0;

   sort_pulse_if bus ();

   red_pitaya_sort_pulse_gen dut (
      .adc_clk_i (clk),
      .adc_rst_i (rst),
      .trig_i    (trig),
      .dac_o     (dac),
      .busy_o    (busy),
      .sys       (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
      bus.sys_addr  = a;
      bus.sys_wdata = d;
      bus.sys_wen   = 1'b1;
      tick();
      bus.sys_wen   = 1'b0;
   endtask

   task automatic bus_rd(input logic [31:0] a, output logic [31:0] d, output logic ack);
      bus.sys_addr = a;
      bus.sys_ren  = 1'b1;
      tick();
      d   = bus.sys_rdata;
      ack = bus.sys_ack;
      bus.sys_ren  = 1'b0;
   endtask

   function automatic logic signed [13:0] exp_dac(input int i, input int amp, input int hp);
      return ((i / hp) % 2 == 0) ? 14'(amp) : 14'(-amp);
   endfunction

   task automatic test_defaults(input string tag);
      logic [31:0] a [8] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h108, 32'h100, 32'h104, 32'h10};
      logic [31:0] e [8] = '{32'd1, 32'd4000, 32'd62500, 32'd10, 32'd0, 32'd0, 32'd0, 32'd0};
      logic [31:0] d;
      logic        ack;
      for (int k = 0; k < 8; k++) begin
         bus_rd(a[k], d, ack);
         vecs++;
         if (d !== e[k] || ack !== 1'b1) begin
            errs++;
            $display("FAIL %s rd[%0h] got %0d ack %b want %0d ack 1", tag, a[k], d, ack, e[k]);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      vecs++;
      if (dac !== 14'sd0 || busy !== 1'b0 || bus.sys_ack !== 1'b0 || bus.sys_err !== 1'b0) begin
         errs++;
         $display("FAIL reset_out got dac %0d busy %b ack %b err %b want 0", dac, busy, bus.sys_ack, bus.sys_err);
      end
      rst = 1'b0;
      tick();
      test_defaults("reset");
   endtask

   task automatic test_single();
      bus_wr(32'h8, 32'd4);
      bus_wr(32'h4, 32'd100);
      bus_wr(32'hC, 32'd2);
      trig = 1'b1;
      tick();
      trig = 1'b0;
      vecs++;
      if (dac !== 14'sd0 || busy !== 1'b0) begin
         errs++;
         $display("FAIL single_pre got dac %0d busy %b want 0 0", dac, busy);
      end
      for (int i = 0; i < 16; i++) begin
         tick();
         vecs++;
         if (dac !== exp_dac(i, 100, 4) || busy !== 1'b1) begin
            errs++;
            $display("FAIL single_c%0d got dac %0d busy %b want %0d 1", i, dac, busy, exp_dac(i, 100, 4));
         end
      end
      tick();
      exp_done++;
      vecs++;
      if (dac !== 14'sd0 || busy !== 1'b0) begin
         errs++;
         $display("FAIL single_end got dac %0d busy %b want 0 0", dac, busy);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] d;
      logic        ack;
      bus_wr(32'h10C, 32'd1);
      exp_done = 0;
      trig = 1'b1;
      tick();
      trig = 1'b0;
      for (int i = 0; i < 16; i++) begin
         tick();
         vecs++;
         if (dac !== exp_dac(i, 100, 4) || busy !== 1'b1) begin
            errs++;
            $display("FAIL retrig_c%0d got dac %0d busy %b want %0d 1", i, dac, busy, exp_dac(i, 100, 4));
         end
         if (i == 6) trig = 1'b1;
         if (i == 8) trig = 1'b0;
      end
      tick();
      exp_done++;
      bus_rd(32'h104, d, ack);
      vecs++;
      if (d !== 32'd1) begin
         errs++;
         $display("FAIL retrig_missed got %0d want 1", d);
      end
      bus_rd(32'h100, d, ack);
      vecs++;
      if (d !== 32'(exp_done)) begin
         errs++;
         $display("FAIL retrig_done got %0d want %0d", d, exp_done);
      end
   endtask

   task automatic test_amp_hp();
      logic [31:0] d;
      logic        ack;
      bus_wr(32'h4, 32'd9000);
      bus_rd(32'h4, d, ack);
      vecs++;
      if (d !== 32'd808) begin
         errs++;
         $display("FAIL amp_mask got %0d want 808", d);
      end
      bus_wr(32'h8, 32'd0);
      trig = 1'b1;
      tick();
      trig = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         vecs++;
         if (dac !== exp_dac(i, 808, 1) || busy !== 1'b1) begin
            errs++;
            $display("FAIL hp0_c%0d got dac %0d busy %b want %0d 1", i, dac, busy, exp_dac(i, 808, 1));
         end
      end
      tick();
      exp_done++;
      vecs++;
      if (dac !== 14'sd0 || busy !== 1'b0) begin
         errs++;
         $display("FAIL hp0_end got dac %0d busy %b want 0 0", dac, busy);
      end
   endtask

   task automatic test_abort();
      logic [31:0] d;
      logic        ack;
      bus_wr(32'h4, 32'd100);
      bus_wr(32'h8, 32'd8);
      trig = 1'b1;
      tick();
      trig = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         vecs++;
         if (dac !== 14'sd100 || busy !== 1'b1) begin
            errs++;
            $display("FAIL abort_pos%0d got dac %0d busy %b want 100 1", i, dac, busy);
         end
      end
      bus_wr(32'h10, 32'd1);
      vecs++;
      if (dac !== 14'sd0 || busy !== 1'b0) begin
         errs++;
         $display("FAIL abort_stop got dac %0d busy %b want 0 0", dac, busy);
      end
      // Disabling mid-burst also stops it.
      trig = 1'b1;
      tick();
      trig = 1'b0;
      tick();
      tick();
      bus_wr(32'h0, 32'd0);
      vecs++;
      if (dac !== 14'sd0 || busy !== 1'b0) begin
         errs++;
         $display("FAIL disable_stop got dac %0d busy %b want 0 0", dac, busy);
      end
      bus_wr(32'h0, 32'd1);
      bus_rd(32'h100, d, ack);
      vecs++;
      if (d !== 32'(exp_done)) begin
         errs++;
         $display("FAIL abort_done got %0d want %0d", d, exp_done);
      end
   endtask

   task automatic test_reset_mid();
      bus_wr(32'h8, 32'd4);
      trig = 1'b1;
      tick();
      trig = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      vecs++;
      if (dac !== -14'sd100) begin
         errs++;
         $display("FAIL rstmid_neg got dac %0d want -100", dac);
      end
      #2 rst = 1'b1;
      #1;
      vecs++;
      if (dac !== 14'sd0 || busy !== 1'b0) begin
         errs++;
         $display("FAIL rstmid_async got dac %0d busy %b want 0 0", dac, busy);
      end
      tick();
      tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      exp_done = 0;
      vecs++;
      if (dac !== 14'sd0 || busy !== 1'b0) begin
         errs++;
         $display("FAIL rstmid_idle got dac %0d busy %b want 0 0", dac, busy);
      end
      test_defaults("rstmid");
   endtask

   task automatic test_midburst_cfg();
      logic [31:0] d;
      logic        ack;
      bus_wr(32'h4, 32'd50);
      bus_wr(32'h8, 32'd2);
      bus_wr(32'hC, 32'd3);
      trig = 1'b1;
      tick();
      trig = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         vecs++;
         if (dac !== exp_dac(i, 50, 2) || busy !== 1'b1) begin
            errs++;
            $display("FAIL mid_c%0d got dac %0d busy %b want %0d 1", i, dac, busy, exp_dac(i, 50, 2));
         end
         if (i == 2) begin
            bus.sys_addr  = 32'hC;
            bus.sys_wdata = 32'd1;
            bus.sys_wen   = 1'b1;
         end
         if (i == 3) bus.sys_wen = 1'b0;
      end
      tick();
      exp_done++;
      vecs++;
      if (dac !== 14'sd0 || busy !== 1'b0) begin
         errs++;
         $display("FAIL mid_end got dac %0d busy %b want 0 0", dac, busy);
      end
      bus_rd(32'hC, d, ack);
      vecs++;
      if (d !== 32'd1) begin
         errs++;
         $display("FAIL mid_ncyc got %0d want 1", d);
      end
   endtask

   task automatic test_counters();
      logic [31:0] d;
      logic        ack;
      bus_wr(32'h0, 32'd0);
      trig = 1'b1;
      tick();
      tick();
      tick();
      trig = 1'b0;
      tick();
      vecs++;
      if (busy !== 1'b0 || dac !== 14'sd0) begin
         errs++;
         $display("FAIL dis_trig got dac %0d busy %b want 0 0", dac, busy);
      end
      bus_wr(32'h0, 32'd1);
      bus_rd(32'h104, d, ack);
      vecs++;
      if (d !== 32'd1) begin
         errs++;
         $display("FAIL cnt_missed got %0d want 1", d);
      end
      bus_rd(32'h100, d, ack);
      vecs++;
      if (d !== 32'(exp_done)) begin
         errs++;
         $display("FAIL cnt_done got %0d want %0d", d, exp_done);
      end
      bus_wr(32'h10C, 32'd1);
      bus_wr(32'hC, 32'd0);
      trig = 1'b1;
      tick();
      trig = 1'b0;
      tick();
      tick();
      vecs++;
      if (busy !== 1'b0) begin
         errs++;
         $display("FAIL ncyc0_busy got %b want 0", busy);
      end
      bus_rd(32'h104, d, ack);
      vecs++;
      if (d !== 32'd0) begin
         errs++;
         $display("FAIL clr_missed got %0d want 0", d);
      end
      bus_rd(32'h100, d, ack);
      vecs++;
      if (d !== 32'd0) begin
         errs++;
         $display("FAIL clr_done got %0d want 0", d);
      end
   endtask

   task automatic test_unmapped();
      logic [31:0] d;
      logic        ack;
      tick();
      vecs++;
      if (bus.sys_ack !== 1'b0) begin
         errs++;
         $display("FAIL ack_idle got %b want 0", bus.sys_ack);
      end
      bus_rd(32'h500, d, ack);
      vecs++;
      if (d !== 32'd0 || ack !== 1'b1) begin
         errs++;
         $display("FAIL unmapped got %0d ack %b want 0 ack 1", d, ack);
      end
      tick();
      vecs++;
      if (bus.sys_ack !== 1'b0) begin
         errs++;
         $display("FAIL ack_drop got %b want 0", bus.sys_ack);
      end
   endtask

   initial begin
      bus.sys_addr  = '0;
      bus.sys_wdata = '0;
      bus.sys_sel   = 4'hF;
      bus.sys_wen   = 1'b0;
      bus.sys_ren   = 1'b0;
      test_reset();
      test_single();
      test_back_to_back();
      test_amp_hp();
      test_abort();
      test_reset_mid();
      test_midburst_cfg();
      test_counters();
      test_unmapped();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
